// File: rtl/alu_cmd_issuer.sv
// Command-side initiator for the 8-bit registered ALU: FIFO-buffered requests, one op in flight,
// tagged responses. Optional divide-by-zero trap enabled by `define ALU_ISSUER_DIV0_CHECK_EN.
module alu_cmd_issuer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [7:0]               cmd_a,
  input  logic [7:0]               cmd_b,
  input  logic [3:0]               cmd_op,
  input  logic [TAG_W-1:0]         cmd_tag,
  output logic [7:0]               alu_a,
  output logic [7:0]               alu_b,
  output logic [3:0]               alu_sel,
  input  logic [7:0]               alu_out,
  input  logic                     alu_carry,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [7:0]               rsp_result,
  output logic                     rsp_carry,
  output logic [TAG_W-1:0]         rsp_tag,
  output logic                     rsp_err,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     busy
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef struct packed {
    logic [7:0]       a;
    logic [7:0]       b;
    logic [3:0]       op;
    logic [TAG_W-1:0] tag;
  } entry_t;

  typedef enum logic [1:0] {IDLE, DRIVE, WAIT, RESP} state_t;

  state_t             state, state_next;
  entry_t             mem [DEPTH];
  entry_t             head;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic               push, pop, fifo_empty;
  logic               issue, head_div0;
  logic [3:0]         inf_op;
  logic [TAG_W-1:0]   inf_tag;
  logic               inf_err;

  assign fifo_empty = (fifo_count == '0);
  assign cmd_ready  = (fifo_count != FULL);
  assign push       = cmd_valid && cmd_ready;
  assign pop        = issue;
  assign head       = mem[rd_ptr];
  assign rsp_valid  = (state == RESP);
  assign busy       = (state != IDLE) || !fifo_empty;

`ifdef ALU_ISSUER_DIV0_CHECK_EN
  assign head_div0 = (head.op == 4'b0011) && (head.b == '0);
`else
  assign head_div0 = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= '{a: cmd_a, b: cmd_b, op: cmd_op, tag: cmd_tag};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // A trapped divide skips DRIVE and enters WAIT directly, so its response
  // appears one clock earlier than an issued op and the ALU inputs stay put.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    case (state)
      IDLE:  issue = !fifo_empty;
      DRIVE: state_next = WAIT;
      WAIT:  state_next = RESP;
      RESP: begin
        if (rsp_ready) begin
          issue = !fifo_empty;
          if (fifo_empty) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (issue) state_next = head_div0 ? WAIT : DRIVE;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_sel    <= '0;
      inf_op     <= '0;
      inf_tag    <= '0;
      inf_err    <= 1'b0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      rsp_tag    <= '0;
      rsp_err    <= 1'b0;
    end else begin
      if (issue) begin
        inf_op  <= head.op;
        inf_tag <= head.tag;
        inf_err <= head_div0;
        if (!head_div0) begin
          alu_a   <= head.a;
          alu_b   <= head.b;
          alu_sel <= head.op;
        end
      end
      if (state == WAIT) begin
        rsp_result <= inf_err ? 8'h00 : alu_out;
        rsp_carry  <= !inf_err && (inf_op == 4'b0000) && alu_carry;
        rsp_tag    <= inf_tag;
        rsp_err    <= inf_err;
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Self-checking bench for alu_cmd_issuer: behavioural registered ALU, directed scenarios and
// randomized traffic compared against a queue-based response model.
`timescale 1ns/1ps
module tb_alu_cmd_issuer;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TAG_W = 4;

  logic               clock = 1'b0;
  logic               reset;
  logic               cmd_valid, cmd_ready;
  logic [7:0]         cmd_a, cmd_b;
  logic [3:0]         cmd_op;
  logic [TAG_W-1:0]   cmd_tag;
  logic [7:0]         alu_a, alu_b, alu_out;
  logic [3:0]         alu_sel;
  logic               alu_carry;
  logic               rsp_valid, rsp_ready, rsp_carry, rsp_err;
  logic [7:0]         rsp_result;
  logic [TAG_W-1:0]   rsp_tag;
  logic [$clog2(DEPTH):0] fifo_count;
  logic               busy;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [7:0]       result;
    logic             carry;
    logic [TAG_W-1:0] tag;
    logic             err;
  } rsp_t;

  rsp_t exp_q[$];

  always #5 clock = ~clock;

  function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    logic [8:0]  s;
    logic [15:0] p;
    s = {1'b0, a} + {1'b0, b};
    p = 16'(a) * 16'(b);
    case (op)
      4'd0:    return s[7:0];
      4'd1:    return a - b;
      4'd2:    return p[7:0];
      4'd3:    return (b == 8'h00) ? 8'hFF : a / b;
      default: return {op, 4'hC};
    endcase
  endfunction

  function automatic logic carry_of(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[8];
  endfunction

  function automatic rsp_t model(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                                 input logic [TAG_W-1:0] tag);
`ifdef ALU_ISSUER_DIV0_CHECK_EN
    if (op == 4'b0011 && b == 8'h00) return '{result: 8'h00, carry: 1'b0, tag: tag, err: 1'b1};
`endif
    return '{result: alu_fn(a, b, op), carry: (op == 4'b0000) ? carry_of(a, b) : 1'b0,
             tag: tag, err: 1'b0};
  endfunction

  // Registered ALU: result and carry of A+B appear one edge after the inputs.
  always @(posedge clock) begin
    alu_out   <= alu_fn(alu_a, alu_b, alu_sel);
    alu_carry <= carry_of(alu_a, alu_b);
  end

  alu_cmd_issuer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .cmd_op(cmd_op), .cmd_tag(cmd_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_carry(rsp_carry),
    .rsp_tag(rsp_tag), .rsp_err(rsp_err), .fifo_count(fifo_count), .busy(busy)
  );

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                      input logic [TAG_W-1:0] tag, input bit track, input int budget);
    bit ok;
    int n;
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_tag = tag; cmd_valid = 1'b1;
    ok = 1'b0; n = 0;
    while (!ok && n < budget) begin
      ok = cmd_ready;
      @(posedge clock); #1;
      n++;
    end
    cmd_valid = 1'b0;
    if (!ok) begin
      checks++; failures++;
      $display("FAIL send_timeout tag=%0d not accepted within %0d cycles", tag, budget);
    end else if (track) begin
      exp_q.push_back(model(a, b, op, tag));
    end
  endtask

  // Waits (bounded) for rsp_valid, samples the response, then spends the handshake edge.
  task automatic get_rsp(output rsp_t got, output int waited, output bit ok);
    waited = 0;
    while (!rsp_valid && waited < 50) begin
      @(posedge clock); #1;
      waited++;
    end
    ok  = rsp_valid;
    got = '{rsp_result, rsp_carry, rsp_tag, rsp_err};
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_a = '0; cmd_b = '0; cmd_op = '0; cmd_tag = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock); #1;
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (fifo_count !== '0) begin failures++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if ({alu_a, alu_b, alu_sel} !== 20'h0) begin failures++; $display("FAIL reset_alu got=%h exp=0", {alu_a, alu_b, alu_sel}); end
    checks++; if ({rsp_result, rsp_carry, rsp_tag, rsp_err} !== '0) begin failures++; $display("FAIL reset_rsp got=%h exp=0", {rsp_result, rsp_carry, rsp_tag, rsp_err}); end
  endtask

  task automatic test_single_add();
    rsp_t got; int w; bit ok;
    rsp_ready = 1'b1;
    send(8'hF0, 8'h20, 4'b0000, 4'd3, 1'b0, 10);
    get_rsp(got, w, ok);
    checks++; if (!ok) begin failures++; $display("FAIL add_timeout rsp_valid never rose"); end
    checks++; if (w != 3) begin failures++; $display("FAIL add_latency got=%0d exp=3", w); end
    checks++; if (got !== rsp_t'({8'h10, 1'b1, 4'd3, 1'b0})) begin failures++; $display("FAIL add_rsp got=%h exp=%h", got, rsp_t'({8'h10, 1'b1, 4'd3, 1'b0})); end
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL add_idle got valid=%b busy=%b exp 0 0", rsp_valid, busy); end
  endtask

  task automatic test_sub_mul();
    rsp_t got; int w; bit ok;
    rsp_ready = 1'b1;
    send(8'h05, 8'h07, 4'b0001, 4'd1, 1'b0, 10);
    get_rsp(got, w, ok);
    checks++; if (!ok || got !== rsp_t'({8'hFE, 1'b0, 4'd1, 1'b0})) begin failures++; $display("FAIL sub_rsp got=%h exp=%h ok=%b", got, rsp_t'({8'hFE, 1'b0, 4'd1, 1'b0}), ok); end
    send(8'h10, 8'h11, 4'b0010, 4'd2, 1'b0, 10);
    get_rsp(got, w, ok);
    checks++; if (!ok || got !== rsp_t'({8'h10, 1'b0, 4'd2, 1'b0})) begin failures++; $display("FAIL mul_rsp got=%h exp=%h ok=%b", got, rsp_t'({8'h10, 1'b0, 4'd2, 1'b0}), ok); end
    checks++; if ({alu_a, alu_b, alu_sel} !== {8'h10, 8'h11, 4'h2}) begin failures++; $display("FAIL mul_alu_hold got=%h exp=%h", {alu_a, alu_b, alu_sel}, {8'h10, 8'h11, 4'h2}); end
  endtask

  task automatic test_passthru();
    rsp_t got; int w; bit ok;
    rsp_ready = 1'b1;
    send(8'h01, 8'h01, 4'b1010, 4'd6, 1'b0, 10);
    get_rsp(got, w, ok);
    checks++; if (!ok || got !== rsp_t'({8'hAC, 1'b0, 4'd6, 1'b0})) begin failures++; $display("FAIL passthru_rsp got=%h exp=%h ok=%b", got, rsp_t'({8'hAC, 1'b0, 4'd6, 1'b0}), ok); end
  endtask

  task automatic test_div0();
    rsp_t got; int w; bit ok;
    logic [19:0] alu_before;
    rsp_ready = 1'b1;
    alu_before = {alu_a, alu_b, alu_sel};
    send(8'h09, 8'h00, 4'b0011, 4'd5, 1'b0, 10);
    get_rsp(got, w, ok);
    checks++; if (!ok) begin failures++; $display("FAIL div0_timeout rsp_valid never rose"); end
`ifdef ALU_ISSUER_DIV0_CHECK_EN
    checks++; if (w != 2) begin failures++; $display("FAIL div0_latency got=%0d exp=2", w); end
    checks++; if (got !== rsp_t'({8'h00, 1'b0, 4'd5, 1'b1})) begin failures++; $display("FAIL div0_rsp got=%h exp=%h", got, rsp_t'({8'h00, 1'b0, 4'd5, 1'b1})); end
    checks++; if ({alu_a, alu_b, alu_sel} !== alu_before) begin failures++; $display("FAIL div0_alu_hold got=%h exp=%h", {alu_a, alu_b, alu_sel}, alu_before); end
`else
    checks++; if (w != 3) begin failures++; $display("FAIL div0_latency got=%0d exp=3", w); end
    checks++; if (got !== rsp_t'({8'hFF, 1'b0, 4'd5, 1'b0})) begin failures++; $display("FAIL div0_rsp got=%h exp=%h", got, rsp_t'({8'hFF, 1'b0, 4'd5, 1'b0})); end
    checks++; if ({alu_a, alu_b, alu_sel} !== {8'h09, 8'h00, 4'h3}) begin failures++; $display("FAIL div0_alu got=%h exp=%h was=%h", {alu_a, alu_b, alu_sel}, {8'h09, 8'h00, 4'h3}, alu_before); end
`endif
  endtask

  task automatic test_fill_stall();
    rsp_t got; int w; bit ok;
    rsp_t exp [DEPTH+1];
    logic [7:0] a, b;
    logic [3:0] op;
    rsp_ready = 1'b0;
    for (int i = 0; i <= DEPTH; i++) begin
      a = 8'($urandom); b = 8'($urandom); op = 4'($urandom_range(0, 2));
      exp[i] = model(a, b, op, TAG_W'(i));
      send(a, b, op, TAG_W'(i), 1'b0, 10);
    end
    checks++; if (fifo_count != ($clog2(DEPTH)+1)'(DEPTH) || cmd_ready !== 1'b0) begin failures++; $display("FAIL fill_full got count=%0d ready=%b exp count=%0d ready=0", fifo_count, cmd_ready, DEPTH); end
    cmd_a = 8'h55; cmd_b = 8'h55; cmd_op = 4'h0; cmd_tag = '1; cmd_valid = 1'b1;
    repeat (4) begin @(posedge clock); #1; end
    cmd_valid = 1'b0;
    checks++; if (fifo_count != ($clog2(DEPTH)+1)'(DEPTH)) begin failures++; $display("FAIL fill_overflow got count=%0d exp=%0d", fifo_count, DEPTH); end
    checks++; if (rsp_valid !== 1'b1 || rsp_tag !== TAG_W'(0)) begin failures++; $display("FAIL fill_stall_hold got valid=%b tag=%0d exp valid=1 tag=0", rsp_valid, rsp_tag); end
    rsp_ready = 1'b1;
    for (int i = 0; i <= DEPTH; i++) begin
      get_rsp(got, w, ok);
      checks++; if (!ok || got !== exp[i]) begin failures++; $display("FAIL fill_rsp%0d got=%h exp=%h ok=%b", i, got, exp[i], ok); end
      // The handshake edge plus two idle edges gives one op per 3 clocks.
      checks++; if (w != ((i == 0) ? 0 : 2)) begin failures++; $display("FAIL fill_gap%0d got=%0d exp=%0d", i, w, (i == 0) ? 0 : 2); end
    end
    checks++; if (busy !== 1'b0 || fifo_count !== '0) begin failures++; $display("FAIL fill_drain got busy=%b count=%0d exp 0 0", busy, fifo_count); end
  endtask

  task automatic test_reset_midflight();
    int seen;
    rsp_ready = 1'b1;
    send(8'h11, 8'h22, 4'h0, 4'd7, 1'b0, 10);
    send(8'h33, 8'h44, 4'h1, 4'd8, 1'b0, 10);
    send(8'h55, 8'h66, 4'h2, 4'd9, 1'b0, 10);
    // First request now in WAIT with the other two queued.
    #2 reset = 1'b1;
    #1;
    checks++; if (fifo_count !== '0 || rsp_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL midreset_state got count=%0d valid=%b busy=%b exp 0 0 0", fifo_count, rsp_valid, busy); end
    checks++; if ({alu_a, alu_b, alu_sel} !== 20'h0) begin failures++; $display("FAIL midreset_alu got=%h exp=0", {alu_a, alu_b, alu_sel}); end
    #3 reset = 1'b0;
    seen = 0;
    repeat (20) begin
      @(posedge clock); #1;
      if (rsp_valid) seen++;
    end
    checks++; if (seen != 0) begin failures++; $display("FAIL midreset_ghost got=%0d responses exp=0", seen); end
  endtask

  task automatic test_random();
    localparam int N = 60;
    exp_q.delete();
    fork
      begin
        logic [7:0] a, b;
        logic [3:0] op;
        for (int i = 0; i < N; i++) begin
          a  = 8'($urandom);
          b  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
          op = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'($urandom_range(0, 3));
          send(a, b, op, TAG_W'(i), 1'b1, 300);
          repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
        end
      end
      begin
        rsp_t got, e;
        int got_n = 0;
        int cyc = 0;
        while (got_n < N && cyc < 6000) begin
          rsp_ready = ($urandom_range(0, 3) != 0);
          if (rsp_valid && rsp_ready) begin
            got = '{rsp_result, rsp_carry, rsp_tag, rsp_err};
            checks++;
            if (exp_q.size() == 0) begin
              failures++; $display("FAIL rand_unexpected got=%h exp=none", got);
            end else begin
              e = exp_q.pop_front();
              if (got !== e) begin failures++; $display("FAIL rand_rsp%0d got=%h exp=%h", got_n, got, e); end
            end
            got_n++;
          end
          @(posedge clock); #1;
          cyc++;
        end
        checks++; if (got_n != N) begin failures++; $display("FAIL rand_count got=%0d exp=%0d", got_n, N); end
      end
    join
    rsp_ready = 1'b0;
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL rand_leftover got=%0d exp=0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_sub_mul();
    test_passthru();
    test_div0();
    test_fill_stall();
    test_reset_midflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule
